// File: rtl/calc_pkg.sv
// Shared definitions for the sequential sign-magnitude calculator.
// Holds the opcode values seen on sel, the FSM state encoding and the
// shift core mode encoding.
`timescale 1ns/1ps
package calc_pkg;

    // Opcodes presented on sel
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b011;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Shift core operating mode
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/calc_shift_core.sv
// Iterative multiply / restoring-divide datapath, one bit per step.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   load          capture operands a, b and mode; clears the bit counter
//   mode          MODE_MUL or MODE_DIV (captured on load)
//   step          perform one shift-add (mul) or shift-subtract-restore (div)
//   a, b          operand magnitudes (mul: a*b, div: a/b)
//   result        product (mul) or zero-extended quotient (div)
//   remainder     division remainder, 0 in mul mode
//   last          the step taken this cycle is the final one
// result and remainder are look-ahead values: they show the register
// contents as they will be after the current step, so the controller can
// capture the final answer on the same edge that performs the last step.
`timescale 1ns/1ps
module calc_shift_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 mode,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH + 1);

    // hi: partial product upper half / partial remainder
    // lo: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] hi_reg, lo_reg, m_reg;
    logic [CW-1:0]    cnt_reg;
    logic             mode_reg;

    logic [WIDTH-1:0] hi_next, lo_next;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, m_reg} : '0);
        shifted = {hi_reg, lo_reg[WIDTH-1]};
        // The true difference is below 2^WIDTH whenever it is kept, so the
        // truncated subtraction is exact in that case.
        trial   = shifted[WIDTH-1:0] - m_reg;
        if (mode_reg == MODE_MUL) begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else if (shifted >= {1'b0, m_reg}) begin
            hi_next = trial;
            lo_next = {lo_reg[WIDTH-2:0], 1'b1};
        end else begin
            hi_next = shifted[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            m_reg    <= '0;
            cnt_reg  <= '0;
            mode_reg <= MODE_MUL;
        end else if (load) begin
            hi_reg   <= '0;
            lo_reg   <= (mode == MODE_MUL) ? b : a;
            m_reg    <= (mode == MODE_MUL) ? a : b;
            cnt_reg  <= '0;
            mode_reg <= mode;
        end else if (step) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign result    = (mode_reg == MODE_MUL) ? {hi_next, lo_next}
                                              : {{WIDTH{1'b0}}, lo_next};
    assign remainder = (mode_reg == MODE_DIV) ? hi_next : '0;
    assign last      = (cnt_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/calculadora_seq.sv
// Clocked sign-magnitude calculator: add, sub, mul, div with start/done.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, sel            launch request (sampled in IDLE) and opcode
//   a, sinal_a            operand A magnitude and sign (1 = negative)
//   b, sinal_b            operand B magnitude and sign
//   saida, sinal_saida    result magnitude (quotient for div) and sign
//   resto, sinal_resto    remainder magnitude and sign (div only)
//   busy                  controller not idle
//   done                  one-cycle completion pulse
//   erro                  divide-by-zero or invalid opcode
// Result outputs are captured only on the edge that enters DONE, so the
// display never observes intermediate values. busy/done are registered
// from the state and therefore trail it by one cycle.
`timescale 1ns/1ps
module calculadora_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           sel,
    input  logic [WIDTH-1:0]     a,
    input  logic                 sinal_a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sinal_b,
    output logic [2*WIDTH-1:0]   saida,
    output logic                 sinal_saida,
    output logic [WIDTH-1:0]     resto,
    output logic                 sinal_resto,
    output logic                 busy,
    output logic                 done,
    output logic                 erro
);

    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             sa_reg, sb_reg;
    logic [2:0]       sel_reg;

    logic               core_load, core_mode, core_step, core_last;
    logic [2*WIDTH-1:0] core_result;
    logic [WIDTH-1:0]   core_rem;

    // Only real iterative work goes to the core; div by zero takes the
    // short CALC path.
    assign core_load = (state == ST_IDLE) && start &&
                       ((sel == OP_MUL) || ((sel == OP_DIV) && (b != '0)));
    assign core_mode = (sel == OP_DIV) ? MODE_DIV : MODE_MUL;
    assign core_step = (state == ST_MUL) || (state == ST_DIV);

    calc_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (core_load),
        .mode      (core_mode),
        .step      (core_step),
        .a         (a),
        .b         (b),
        .result    (core_result),
        .remainder (core_rem),
        .last      (core_last)
    );

    // Add/sub path: sub is add with B's sign flipped.
    logic           eff_sb;
    logic [WIDTH:0] add_mag;
    logic           add_sign;
    logic           arith_op;

    always_comb begin
        eff_sb   = (sel_reg == OP_SUB) ? ~sb_reg : sb_reg;
        arith_op = (sel_reg == OP_ADD) || (sel_reg == OP_SUB);
        if (sa_reg == eff_sb) begin
            add_mag  = {1'b0, a_reg} + {1'b0, b_reg};
            add_sign = sa_reg;
        end else if (a_reg >= b_reg) begin
            add_mag  = {1'b0, a_reg - b_reg};
            add_sign = sa_reg;
        end else begin
            add_mag  = {1'b0, b_reg - a_reg};
            add_sign = eff_sb;
        end
        // Zero magnitude never carries a negative sign
        if (add_mag == '0)
            add_sign = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            sa_reg      <= 1'b0;
            sb_reg      <= 1'b0;
            sel_reg     <= '0;
            saida       <= '0;
            sinal_saida <= 1'b0;
            resto       <= '0;
            sinal_resto <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            erro        <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE);
            done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        sa_reg  <= sinal_a;
                        sb_reg  <= sinal_b;
                        sel_reg <= sel;
                        if (sel == OP_MUL)
                            state <= ST_MUL;
                        else if ((sel == OP_DIV) && (b != '0))
                            state <= ST_DIV;
                        else
                            state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    resto       <= '0;
                    sinal_resto <= 1'b0;
                    if (arith_op) begin
                        saida       <= {{(WIDTH-1){1'b0}}, add_mag};
                        sinal_saida <= add_sign;
                        erro        <= 1'b0;
                    end else begin
                        saida       <= '0;
                        sinal_saida <= 1'b0;
                        erro        <= 1'b1;
                    end
                    state <= ST_DONE;
                end
                ST_MUL, ST_DIV: begin
                    if (core_last) begin
                        saida       <= core_result;
                        sinal_saida <= (sa_reg ^ sb_reg) & (|core_result);
                        resto       <= core_rem;
                        sinal_resto <= sa_reg & (|core_rem);
                        erro        <= 1'b0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calculadora_seq.sv
`timescale 1ns/1ps
module tb_calculadora_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2:0]     sel;
    logic [W-1:0]   a, b;
    logic           sinal_a, sinal_b;
    logic [2*W-1:0] saida;
    logic           sinal_saida;
    logic [W-1:0]   resto;
    logic           sinal_resto;
    logic           busy, done, erro;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calculadora_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
        .a(a), .sinal_a(sinal_a), .b(b), .sinal_b(sinal_b),
        .saida(saida), .sinal_saida(sinal_saida),
        .resto(resto), .sinal_resto(sinal_resto),
        .busy(busy), .done(done), .erro(erro)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: signed integer arithmetic, C-style truncating division.
    function automatic void model(input logic [2:0] s, input int av, input int bv,
                                  input bit sa, input bit sb,
                                  output int q, output bit qs, output int r,
                                  output bit rs, output bit e, output int lat);
        longint sA, sB, res, rr;
        sA = sa ? -longint'(av) : longint'(av);
        sB = sb ? -longint'(bv) : longint'(bv);
        res = 0; rr = 0; e = 0; lat = 2;
        case (s)
            3'b100: res = sA + sB;
            3'b010: res = sA - sB;
            3'b001: begin res = sA * sB; lat = W + 1; end
            3'b011: begin
                if (bv == 0) e = 1;
                else begin res = sA / sB; rr = sA % sB; lat = W + 1; end
            end
            default: e = 1;
        endcase
        q  = int'(res < 0 ? -res : res);
        qs = res < 0;
        r  = int'(rr < 0 ? -rr : rr);
        rs = rr < 0;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] s, input int av, input int bv,
                          input bit sa, input bit sb, input bit poke);
        int q, r, lat, got_lat;
        bit qs, rs, e, changed;
        logic [2*W-1:0] prev;
        model(s, av, bv, sa, sb, q, qs, r, rs, e, lat);
        prev = saida;
        changed = 0;
        got_lat = 0;
        @(negedge clk);
        sel = s; a = W'(av); b = W'(bv); sinal_a = sa; sinal_b = sb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 1) check({tag, " busy_start"}, 64'(busy), 64'd1);
            if (poke && n == 2) begin
                start = 1'b1; sel = 3'b100; a = ~a; b = 8'd3; sinal_a = ~sinal_a;
            end
            if (poke && n == 3) start = 1'b0;
            if (done) begin got_lat = n; break; end
            if (n < lat - 1 && saida !== prev) changed = 1;
        end
        $display("op %s sel=%b a=%0d/%0d b=%0d/%0d -> saida=%0d/%0d resto=%0d/%0d erro=%0d lat=%0d",
                 tag, s, av, sa, bv, sb, saida, sinal_saida, resto, sinal_resto, erro, got_lat);
        check({tag, " latency"}, 64'(got_lat), 64'(lat));
        check({tag, " saida"}, 64'(saida), 64'(q));
        check({tag, " sinal_saida"}, 64'(sinal_saida), 64'(qs));
        check({tag, " resto"}, 64'(resto), 64'(r));
        check({tag, " sinal_resto"}, 64'(sinal_resto), 64'(rs));
        check({tag, " erro"}, 64'(erro), 64'(e));
        check({tag, " busy_done"}, 64'(busy), 64'd1);
        check({tag, " hold"}, 64'(changed), 64'd0);
        @(posedge clk); #1;
        check({tag, " done_width"}, 64'(done), 64'd0);
        check({tag, " busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [2:0] ops [6];
        logic [2:0] s;
        bit saw_done;
        ops[0] = 3'b100; ops[1] = 3'b010; ops[2] = 3'b001;
        ops[3] = 3'b011; ops[4] = 3'b111; ops[5] = 3'b000;
        rst_n = 1'b0; start = 1'b0; sel = '0; a = '0; b = '0; sinal_a = 0; sinal_b = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset saida", 64'(saida), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset erro", 64'(erro), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add1", 3'b100, 100, 50, 0, 1, 0);
        run_op("subz", 3'b010, 7, 7, 1, 1, 0);
        run_op("addmax", 3'b100, 255, 255, 0, 0, 0);
        run_op("mulmax", 3'b001, 255, 255, 1, 0, 1);
        run_op("div1", 3'b011, 200, 7, 0, 1, 0);
        run_op("div2", 3'b011, 6, 3, 1, 0, 0);
        run_op("div0", 3'b011, 5, 0, 0, 0, 0);
        run_op("badop", 3'b111, 9, 4, 1, 0, 0);
        run_op("clrerr", 3'b100, 12, 30, 1, 0, 0);

        // Reset while multiplying
        @(negedge clk);
        sel = 3'b001; a = 8'd13; b = 8'd11; sinal_a = 1; sinal_b = 0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst saida", 64'(saida), 64'd0);
        check("rst sinal_saida", 64'(sinal_saida), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst erro", 64'(erro), 64'd0);
        saw_done = 0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        check("rst no_done", 64'(saw_done), 64'd0);
        run_op("postrst", 3'b100, 1, 2, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            s = ops[$urandom_range(0, 5)];
            run_op($sformatf("rnd%0d", i), s, int'($urandom_range(0, 255)),
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
